// File: rtl/scan_display_decoder.sv
// Monitors the multiplexed digit bus (num + active-low an_sel) and rebuilds the
// four displayed digits, committing them only when a full in-order frame is seen.
module scan_display_decoder #(
   parameter int SETTLE = 4,
   parameter int FCNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        an_sel,
   input  logic [3:0]        num,
   output logic [3:0]        ones,
   output logic [3:0]        tens,
   output logic [3:0]        hundreds,
   output logic [3:0]        letter,
   output logic              frame_valid,
   output logic              locked,
   output logic              err_anode,
   output logic              err_order,
   output logic [FCNT_W-1:0] frame_count
);

   localparam int RUN_W = $clog2(SETTLE + 1);

   localparam logic [2:0] SYNC     = 3'd0;
   localparam logic [2:0] EXP_ONES = 3'd1;
   localparam logic [2:0] EXP_TENS = 3'd2;
   localparam logic [2:0] EXP_HUND = 3'd3;
   localparam logic [2:0] EXP_LET  = 3'd4;

   function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] r);
      if (r >= RUN_W'(SETTLE)) return RUN_W'(SETTLE);
      else                     return r + 1'b1;
   endfunction

   logic [2:0]       state, state_n;
   logic [3:0]       prev_an;
   logic [RUN_W-1:0] run, run_next;
   logic [3:0]       sh_ones, sh_tens, sh_hund;
   logic [3:0]       sh_ones_n, sh_tens_n, sh_hund_n;
   logic             capture, changed;
   logic [1:0]       idx, exp_idx;
   logic             legal, blank, illegal;
   logic             commit, e_anode, e_order;

   // Dwell filter: a capture fires once, on the cycle the dwell reaches SETTLE.
   always_comb begin
      changed  = (an_sel != prev_an);
      run_next = changed ? RUN_W'(1) : sat_inc(run);
      capture  = (run_next == RUN_W'(SETTLE)) && (changed || (run < RUN_W'(SETTLE)));
   end

   always_comb begin
      idx   = 2'd0;
      legal = 1'b0;
      blank = (an_sel == 4'b1111);
      case (an_sel)
         4'b0111: begin idx = 2'd0; legal = 1'b1; end
         4'b1011: begin idx = 2'd1; legal = 1'b1; end
         4'b1101: begin idx = 2'd2; legal = 1'b1; end
         4'b1110: begin idx = 2'd3; legal = 1'b1; end
         default: ;
      endcase
      illegal = !legal && !blank;
      case (state)
         EXP_TENS: exp_idx = 2'd1;
         EXP_HUND: exp_idx = 2'd2;
         EXP_LET:  exp_idx = 2'd3;
         default:  exp_idx = 2'd0;
      endcase
   end

   // Frame sequencer: partial digits live in the shadows until the letter arrives.
   always_comb begin
      state_n   = state;
      sh_ones_n = sh_ones;
      sh_tens_n = sh_tens;
      sh_hund_n = sh_hund;
      commit    = 1'b0;
      e_anode   = 1'b0;
      e_order   = 1'b0;
      if (capture) begin
         if (illegal) begin
            e_anode   = 1'b1;
            state_n   = SYNC;
            sh_ones_n = 4'd0;
            sh_tens_n = 4'd0;
            sh_hund_n = 4'd0;
         end else if (legal) begin
            if (state == SYNC) begin
               if (idx == 2'd0) begin
                  sh_ones_n = num;
                  state_n   = EXP_TENS;
               end
            end else if (idx == exp_idx) begin
               case (idx)
                  2'd0:    begin sh_ones_n = num; state_n = EXP_TENS; end
                  2'd1:    begin sh_tens_n = num; state_n = EXP_HUND; end
                  2'd2:    begin sh_hund_n = num; state_n = EXP_LET;  end
                  default: begin commit = 1'b1;   state_n = EXP_ONES; end
               endcase
            end else begin
               e_order = 1'b1;
               if (idx == 2'd0) begin
                  sh_ones_n = num;
                  state_n   = EXP_TENS;
               end else begin
                  state_n = SYNC;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SYNC;
         prev_an     <= 4'b1111;
         run         <= '0;
         sh_ones     <= 4'd0;
         sh_tens     <= 4'd0;
         sh_hund     <= 4'd0;
         ones        <= 4'd0;
         tens        <= 4'd0;
         hundreds    <= 4'd0;
         letter      <= 4'd0;
         frame_valid <= 1'b0;
         err_anode   <= 1'b0;
         err_order   <= 1'b0;
         locked      <= 1'b0;
         frame_count <= '0;
      end else begin
         state       <= state_n;
         prev_an     <= an_sel;
         run         <= run_next;
         sh_ones     <= sh_ones_n;
         sh_tens     <= sh_tens_n;
         sh_hund     <= sh_hund_n;
         frame_valid <= commit;
         err_anode   <= e_anode;
         err_order   <= e_order;
         locked      <= (state_n != SYNC);
         if (commit) begin
            ones        <= sh_ones;
            tens        <= sh_tens;
            hundreds    <= sh_hund;
            letter      <= num;
            frame_count <= frame_count + 1'b1;
         end
      end
   end

endmodule
